// File: rtl/timer_pkg.sv
// Shared encodings for the timer compare bank: register selects and control bits.
package timer_pkg;

  localparam logic [1:0] REG_CMP    = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned CTRL_ARM      = 0;
  localparam int unsigned CTRL_PERIODIC = 1;

  // Channel-select width, never below one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_cmp_chan.sv
// One compare channel: cmp/period/ctrl registers, hit detection, reload and sticky pending.
module timer_cmp_chan
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] mtime_nxt_i,
  input  logic             wr_sel_i,
  input  logic [1:0]       wr_reg_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             irq_clr_i,
  output logic             irq_o,
  output logic             armed_o
);

  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             armed_q, armed_d;
  logic             periodic_q, periodic_d;
  logic             irq_q, irq_d;
  logic             hold_q, hold_d;
  logic             hit_c;

  // hold_q parks a periodic channel whose period is zero until it is written again.
  assign hit_c = tick_i && armed_q && !hold_q && !wr_sel_i && (mtime_nxt_i == cmp_q);

  always_comb begin
    cmp_d      = cmp_q;
    period_d   = period_q;
    armed_d    = armed_q;
    periodic_d = periodic_q;
    hold_d     = hold_q;
    irq_d      = hit_c | (irq_q & ~irq_clr_i);

    if (hit_c) begin
      if (periodic_q) begin
        cmp_d = cmp_q + period_q;
        if (period_q == '0) hold_d = 1'b1;
      end else begin
        armed_d = 1'b0;
      end
    end

    if (wr_sel_i) begin
      hold_d = 1'b0;
      case (wr_reg_i)
        REG_CMP:    cmp_d = wr_data_i;
        REG_PERIOD: period_d = wr_data_i;
        REG_CTRL: begin
          armed_d    = wr_data_i[CTRL_ARM];
          periodic_d = wr_data_i[CTRL_PERIODIC];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      cmp_q      <= '1;
      period_q   <= '0;
      armed_q    <= 1'b0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      cmp_q      <= cmp_d;
      period_q   <= period_d;
      armed_q    <= armed_d;
      periodic_q <= periodic_d;
      irq_q      <= irq_d;
      hold_q     <= hold_d;
    end
  end

  assign irq_o   = irq_q;
  assign armed_o = armed_q;

endmodule

// File: rtl/timer_cmp_bank.sv
// Free-running prescaled timer with NCH compare channels.
// Optional sticky wrap flag built when TIMER_CMP_BANK_OVF_EN is defined.
module timer_cmp_bank
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NCH     = 2,
  parameter int unsigned PRESC_W = 8
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     en,
  input  logic [PRESC_W-1:0]       presc,
  input  logic                     wr_en,
  input  logic [ch_width(NCH)-1:0] wr_ch,
  input  logic [1:0]               wr_reg,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NCH-1:0]           irq_clr,
  output logic [NCH-1:0]           irq,
  output logic [NCH-1:0]           armed,
  output logic [WIDTH-1:0]         mtime,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int unsigned CH_W = ch_width(NCH);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [WIDTH-1:0]   mtime_q, mtime_d;
  logic [WIDTH-1:0]   mtime_nxt_c;
  logic               tick_c;
  logic [NCH-1:0]     wr_sel_c;

  // >= lets a lowered divide value take effect on the next enabled cycle.
  assign tick_c      = en && (presc_cnt_q >= presc);
  assign mtime_nxt_c = mtime_q + WIDTH'(1);

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    mtime_d     = mtime_q;
    if (tick_c) begin
      presc_cnt_d = '0;
      mtime_d     = mtime_nxt_c;
    end else if (en) begin
      presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      presc_cnt_q <= '0;
      mtime_q     <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      mtime_q     <= mtime_d;
    end
  end

  assign mtime = mtime_q;

  // Out-of-range channels and the reserved register select match no channel.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign wr_sel_c[i] = wr_en && (wr_reg != REG_RSVD) && (wr_ch == CH_W'(i));

    timer_cmp_chan #(.WIDTH(WIDTH)) u_chan (
      .clk         (clk),
      .resetb      (resetb),
      .tick_i      (tick_c),
      .mtime_nxt_i (mtime_nxt_c),
      .wr_sel_i    (wr_sel_c[i]),
      .wr_reg_i    (wr_reg),
      .wr_data_i   (wr_data),
      .irq_clr_i   (irq_clr[i]),
      .irq_o       (irq[i]),
      .armed_o     (armed[i])
    );
  end

`ifdef TIMER_CMP_BANK_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q & ~ovf_clr;
    if (tick_c && (mtime_q == '1)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetb) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_timer_cmp_bank.sv
// Directed bench for timer_cmp_bank (WIDTH=8, NCH=2, PRESC_W=8).
module tb_timer_cmp_bank;

  logic       clk;
  logic       resetb;
  logic       en;
  logic [7:0] presc;
  logic       wr_en;
  logic [0:0] wr_ch;
  logic [1:0] wr_reg;
  logic [7:0] wr_data;
  logic [1:0] irq_clr;
  logic [1:0] irq;
  logic [1:0] armed;
  logic [7:0] mtime;
  logic       ovf;
  logic       ovf_clr;

  int errors = 0;
  int checks = 0;

`ifdef TIMER_CMP_BANK_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  timer_cmp_bank #(.WIDTH(8), .NCH(2), .PRESC_W(8)) dut (
    .clk     (clk),
    .resetb  (resetb),
    .en      (en),
    .presc   (presc),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_reg  (wr_reg),
    .wr_data (wr_data),
    .irq_clr (irq_clr),
    .irq     (irq),
    .armed   (armed),
    .mtime   (mtime),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int ch, input logic [1:0] r, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_ch   = 1'(ch);
    wr_reg  = r;
    wr_data = d;
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    resetb  = 1'b0;
    en      = 1'b1;
    presc   = 8'd0;
    wr_en   = 1'b0;
    irq_clr = 2'b00;
    ovf_clr = 1'b0;
    step(3);
    resetb  = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mtime !== 8'd0) begin errors++; $display("FAIL reset_mtime: got %0d expected 0", mtime); end
    checks++; if (irq !== 2'b00) begin errors++; $display("FAIL reset_irq: got %b expected 00", irq); end
    checks++; if (armed !== 2'b00) begin errors++; $display("FAIL reset_armed: got %b expected 00", armed); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    step(5);
    checks++; if (mtime !== 8'd5) begin errors++; $display("FAIL count_presc0: got %0d expected 5", mtime); end
    // Arm ch0 with its reset compare value: hit must land on mtime=255.
    do_reset();
    wr(0, 2'd2, 8'h01);
    step(253);
    checks++; if (irq[0] !== 1'b0 || mtime !== 8'd254) begin errors++; $display("FAIL cmp_reset_early: got irq=%b mtime=%0d expected irq=0 mtime=254", irq[0], mtime); end
    step(1);
    checks++; if (irq[0] !== 1'b1) begin errors++; $display("FAIL cmp_reset_hit: got %b expected 1", irq[0]); end
    checks++; if (armed[0] !== 1'b0) begin errors++; $display("FAIL cmp_reset_disarm: got %b expected 0", armed[0]); end
  endtask

  task automatic test_oneshot();
    do_reset();
    presc = 8'd3;
    wr(0, 2'd0, 8'd4);
    wr(0, 2'd2, 8'h01);
    checks++; if (armed !== 2'b01) begin errors++; $display("FAIL oneshot_armed: got %b expected 01", armed); end
    step(13);
    checks++; if (mtime !== 8'd3 || irq[0] !== 1'b0) begin errors++; $display("FAIL oneshot_pre: got mtime=%0d irq=%b expected 3/0", mtime, irq[0]); end
    step(1);
    checks++; if (mtime !== 8'd4 || irq[0] !== 1'b1) begin errors++; $display("FAIL oneshot_hit: got mtime=%0d irq=%b expected 4/1", mtime, irq[0]); end
    checks++; if (armed[0] !== 1'b0) begin errors++; $display("FAIL oneshot_disarm: got %b expected 0", armed[0]); end
    irq_clr = 2'b01;
    step(1);
    irq_clr = 2'b00;
    checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL oneshot_clr: got %b expected 0", irq[0]); end
    step(1030);
    checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL oneshot_rehit: got %b expected 0", irq[0]); end
  endtask

  task automatic test_periodic();
    do_reset();
    wr(1, 2'd0, 8'd10);
    wr(1, 2'd1, 8'd10);
    wr(1, 2'd2, 8'h03);
    step(6);
    checks++; if (mtime !== 8'd9 || irq[1] !== 1'b0) begin errors++; $display("FAIL per_pre: got mtime=%0d irq=%b expected 9/0", mtime, irq[1]); end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++; if (irq[1] !== 1'b1 || mtime !== 8'(10 * k)) begin errors++; $display("FAIL per_hit%0d: got mtime=%0d irq=%b expected %0d/1", k, mtime, irq[1], 10 * k); end
      checks++; if (armed[1] !== 1'b1) begin errors++; $display("FAIL per_armed%0d: got %b expected 1", k, armed[1]); end
      irq_clr = 2'b10;
      step(1);
      irq_clr = 2'b00;
      step(7);
      checks++; if (irq[1] !== 1'b0) begin errors++; $display("FAIL per_gap%0d: got %b expected 0", k, irq[1]); end
      step(1);
    end
  endtask

  task automatic test_priority();
    do_reset();
    wr(0, 2'd0, 8'd5);
    wr(0, 2'd1, 8'd10);
    wr(0, 2'd2, 8'h03);
    step(1);
    irq_clr = 2'b01;
    step(1);
    checks++; if (mtime !== 8'd5 || irq[0] !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got mtime=%0d irq=%b expected 5/1", mtime, irq[0]); end
    step(1);
    irq_clr = 2'b00;
    checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL prio_clr: got %b expected 0", irq[0]); end
    step(8);
    wr(0, 2'd0, 8'd50);
    checks++; if (mtime !== 8'd15 || irq[0] !== 1'b0) begin errors++; $display("FAIL write_suppress: got mtime=%0d irq=%b expected 15/0", mtime, irq[0]); end
    checks++; if (armed[0] !== 1'b1) begin errors++; $display("FAIL write_keep_armed: got %b expected 1", armed[0]); end
    step(34);
    checks++; if (mtime !== 8'd49 || irq[0] !== 1'b0) begin errors++; $display("FAIL cmp50_pre: got mtime=%0d irq=%b expected 49/0", mtime, irq[0]); end
    step(1);
    checks++; if (irq[0] !== 1'b1) begin errors++; $display("FAIL cmp50_hit: got %b expected 1", irq[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr(0, 2'd0, 8'd7);
    wr(1, 2'd0, 8'd7);
    wr(0, 2'd2, 8'h01);
    wr(1, 2'd2, 8'h01);
    step(2);
    checks++; if (irq !== 2'b00) begin errors++; $display("FAIL dual_pre: got %b expected 00", irq); end
    step(1);
    checks++; if (irq !== 2'b11 || armed !== 2'b00) begin errors++; $display("FAIL dual_hit: got irq=%b armed=%b expected 11/00", irq, armed); end
  endtask

  task automatic test_freeze_reset();
    do_reset();
    en = 1'b0;
    wr(1, 2'd2, 8'h01);
    checks++; if (armed !== 2'b10 || mtime !== 8'd0) begin errors++; $display("FAIL frz_arm: got armed=%b mtime=%0d expected 10/0", armed, mtime); end
    en = 1'b1;
    presc = 8'd2;
    step(7);
    checks++; if (mtime !== 8'd2) begin errors++; $display("FAIL frz_pre: got %0d expected 2", mtime); end
    en = 1'b0;
    step(7);
    checks++; if (mtime !== 8'd2) begin errors++; $display("FAIL frz_hold: got %0d expected 2", mtime); end
    en = 1'b1;
    step(1);
    checks++; if (mtime !== 8'd2) begin errors++; $display("FAIL frz_cnt_kept: got %0d expected 2", mtime); end
    step(1);
    checks++; if (mtime !== 8'd3) begin errors++; $display("FAIL frz_resume: got %0d expected 3", mtime); end
    step(1);
    resetb = 1'b0;
    wr(0, 2'd2, 8'h01);
    checks++; if (mtime !== 8'd0 || armed !== 2'b00 || irq !== 2'b00) begin errors++; $display("FAIL mid_reset: got mtime=%0d armed=%b irq=%b expected 0/00/00", mtime, armed, irq); end
    resetb = 1'b1;
    step(2);
    checks++; if (mtime !== 8'd0) begin errors++; $display("FAIL presc_cnt_reset: got %0d expected 0", mtime); end
    step(1);
    checks++; if (mtime !== 8'd1) begin errors++; $display("FAIL post_reset_tick: got %0d expected 1", mtime); end
  endtask

  task automatic test_ovf();
    do_reset();
    step(255);
    checks++; if (mtime !== 8'd255 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre: got mtime=%0d ovf=%b expected 255/0", mtime, ovf); end
    step(1);
    checks++; if (mtime !== 8'd0 || ovf !== OVF_EXP) begin errors++; $display("FAIL ovf_wrap: got mtime=%0d ovf=%b expected 0/%b", mtime, ovf, OVF_EXP); end
    step(1);
    checks++; if (ovf !== OVF_EXP) begin errors++; $display("FAIL ovf_sticky: got %b expected %b", ovf, OVF_EXP); end
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
    step(253);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    checks++; if (mtime !== 8'd0 || ovf !== OVF_EXP) begin errors++; $display("FAIL ovf_set_wins: got mtime=%0d ovf=%b expected 0/%b", mtime, ovf, OVF_EXP); end
  endtask

  initial begin
    resetb  = 1'b0;
    en      = 1'b0;
    presc   = 8'd0;
    wr_en   = 1'b0;
    wr_ch   = 1'b0;
    wr_reg  = 2'd0;
    wr_data = 8'd0;
    irq_clr = 2'b00;
    ovf_clr = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_priority();
    test_back_to_back();
    test_freeze_reset();
    test_ovf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
